traffic_display_driver: RTL and testbench
=========================================

TRAFFIC_DISPLAY_DRIVER -- requirements
Module: traffic_display_driver

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 50000, meaning clk cycles per digit scan slot (minimum 2).
REQ-002 The block SHALL have parameter BLINK_DIV, default 25000000, meaning clk cycles per blink half-period (minimum 2).
REQ-003 Port clk  input  1  the single clock; all logic is on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Port east_west  input  2  E-W light code: 00 green, 01 yellow, 10 red, 11 illegal.
REQ-006 Port south_north  input  2  N-S light code, same encoding as east_west.
REQ-007 Port countdown  input  8  remaining phase time, unsigned binary 0..255.
REQ-008 Port ew_led  output  3  E-W lamps {red, yellow, green}, active-high.
REQ-009 Port sn_led  output  3  N-S lamps {red, yellow, green}, active-high.
REQ-010 Port seg  output  8  segments {dp,g,f,e,d,c,b,a}, active-low.
REQ-011 Port an  output  4  digit enables, active-low; an[0] is the units digit.
REQ-012 Port fault  output  1  latched illegal or conflicting light state.

Function
REQ-013 All inputs SHALL be registered once; all decoding SHALL use the registered copies.
REQ-014 Lamp decode SHALL be 00->green, 01->yellow, 10->red, with ew_led/sn_led changing 2 cycles after the input change.
REQ-015 With blink enabled, a yellow lamp SHALL be ANDed with blink_phase, which toggles every BLINK_DIV cycles and is 1 after reset.
REQ-016 Fault SHALL be detected when either registered code is 11, or neither registered code is 10; fault SHALL rise the cycle after detection and stay set until rst.
REQ-017 While fault is set, ew_led and sn_led SHALL both be 3'b010, subject to REQ-015 blinking.
REQ-018 A BCD conversion SHALL start when the registered countdown differs from the last converted value, and SHALL not start while a conversion is busy.
REQ-019 Conversion SHALL be sequential shift-add-3: 1 load cycle plus 8 shift cycles, with new hundreds/tens/units visible 9 cycles after start.
REQ-020 The displayed BCD SHALL hold its previous value until a conversion completes; if countdown changes during a conversion, one further conversion SHALL follow.
REQ-021 The scan counter SHALL advance the active digit 0->1->2->3->0 every SCAN_DIV cycles, with exactly one an bit low.
REQ-022 Digits 0-2 SHALL show units, tens and hundreds; a leading zero in hundreds, and in tens when hundreds is zero, SHALL be blanked; units SHALL always show.
REQ-023 Digit 3 SHALL be blank normally and SHALL show 'F' while fault is set; during fault, digits 0-2 SHALL be blank.
REQ-024 dp SHALL always be off (1).

Reset
REQ-025 On rst, the block SHALL set ew_led=3'b000, sn_led=3'b000, seg=8'hFF, an=4'b1110, fault=0, BCD=000, scan and blink counters=0, blink_phase=1 and converter idle.
REQ-026 rst asserted mid-conversion or mid-scan SHALL abort all activity, leaving the outputs of REQ-025 on the following cycle.

Configuration
REQ-027 With macro TRAFFIC_DISP_BLINK_EN defined, the blink counter and REQ-015 blinking SHALL be compiled in.
REQ-028 Without TRAFFIC_DISP_BLINK_EN, yellow lamps SHALL be steady, the blink logic SHALL be absent, and BLINK_DIV SHALL be ignored.

Structure
REQ-029 Package traffic_pkg SHALL hold the light-code constants (GREEN, YELLOW, RED, ILLEGAL), the seven-segment patterns for 0-9, 'F' and blank, and the digit count 4.
REQ-030 The BCD converter SHALL be sub-module bin2bcd_seq with ports clk, rst, start, bin[7:0], busy, done, hund[3:0], tens[3:0], units[3:0].

Verification (SCAN_DIV=4, BLINK_DIV=8)
REQ-031 Reset, then ew=10, sn=00, cd=45 -> ew_led=100, sn_led=001; after conversion, digits read blank,4,5 with an cycling every 4 cycles.
REQ-032 ew=10, sn=01 held 40 cycles -> sn_led yellow bit toggles every 8 cycles (macro on), or stays steady (macro off).
REQ-033 cd steps 100->99 mid-conversion -> display shows 1,0,0 and then 9,9 with hundreds blanked; no intermediate garbage is shown.
REQ-034 ew=00, sn=00 for 1 cycle, then legal codes -> fault=1 and stays 1; digit 3 shows 'F'; both lamps are yellow.
REQ-035 sn=11 -> fault=1; rst pulse -> all outputs match REQ-025 on the next cycle.
REQ-036 cd=0 and cd=255 -> display shows "  0" and "255".

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared constants for the traffic display driver: light codes, seven-segment
// patterns, converter states and the double-dabble step.
package traffic_pkg;

    typedef enum logic [1:0] {
        GREEN   = 2'b00,
        YELLOW  = 2'b01,
        RED     = 2'b10,
        ILLEGAL = 2'b11
    } light_e;

    typedef enum logic {
        CONV_IDLE  = 1'b0,
        CONV_SHIFT = 1'b1
    } conv_state_e;

    localparam int NUM_DIGITS = 4;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_F     = 8'h8E;

    // Active-low {dp,g,f,e,d,c,b,a}; dp is always off.
    function automatic logic [7:0] segOf(input logic [3:0] value);
        case (value)
            4'd0:    return 8'hC0;
            4'd1:    return 8'hF9;
            4'd2:    return 8'hA4;
            4'd3:    return 8'hB0;
            4'd4:    return 8'h99;
            4'd5:    return 8'h92;
            4'd6:    return 8'h82;
            4'd7:    return 8'hF8;
            4'd8:    return 8'h80;
            4'd9:    return 8'h90;
            default: return SEG_BLANK;
        endcase
    endfunction

    function automatic logic [2:0] lampOf(input light_e code);
        case (code)
            GREEN:   return 3'b001;
            YELLOW:  return 3'b010;
            RED:     return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // One shift-add-3 step over {hundreds, tens, units, binary}.
    function automatic logic [19:0] dabbleStep(input logic [19:0] s);
        logic [19:0] a;
        a = s;
        for (int i = 0; i < 3; i++) begin
            if (a[8 + 4*i +: 4] >= 4'd5) begin
                a[8 + 4*i +: 4] = a[8 + 4*i +: 4] + 4'd3;
            end
        end
        return {a[18:0], 1'b0};
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter: one load cycle followed by
// eight shift-add-3 cycles; results only change when a conversion completes.
module bin2bcd_seq
    import traffic_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] bin,
    output logic       busy,
    output logic       done,
    output logic [3:0] hund,
    output logic [3:0] tens,
    output logic [3:0] units
);

    conv_state_e state_q, state_d;
    logic [19:0] shift_q, shift_d;
    logic [2:0]  count_q, count_d;
    logic        done_q, done_d;
    logic [3:0]  hund_q, hund_d, tens_q, tens_d, units_q, units_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CONV_IDLE;
            shift_q <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            hund_q  <= '0;
            tens_q  <= '0;
            units_q <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            count_q <= count_d;
            done_q  <= done_d;
            hund_q  <= hund_d;
            tens_q  <= tens_d;
            units_q <= units_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        count_d = count_q;
        done_d  = 1'b0;
        hund_d  = hund_q;
        tens_d  = tens_q;
        units_d = units_q;
        case (state_q)
            CONV_IDLE: begin
                if (start) begin
                    shift_d = {12'd0, bin};
                    count_d = 3'd0;
                    state_d = CONV_SHIFT;
                end
            end
            CONV_SHIFT: begin
                shift_d = dabbleStep(shift_q);
                count_d = count_q + 3'd1;
                if (count_q == 3'd7) begin
                    state_d = CONV_IDLE;
                    done_d  = 1'b1;
                    {hund_d, tens_d, units_d} = shift_d[19:8];
                end
            end
            default: state_d = CONV_IDLE;
        endcase
    end

    assign busy  = (state_q == CONV_SHIFT);
    assign done  = done_q;
    assign hund  = hund_q;
    assign tens  = tens_q;
    assign units = units_q;

endmodule

// File: rtl/traffic_display_driver.sv
// Traffic light lamp driver with fault latch and 4-digit multiplexed countdown
// display. Define TRAFFIC_DISP_BLINK_EN to make yellow lamps blink.
module traffic_display_driver
    import traffic_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 25000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            east_west,
    input  logic [1:0]            south_north,
    input  logic [7:0]            countdown,
    output logic [2:0]            ew_led,
    output logic [2:0]            sn_led,
    output logic [7:0]            seg,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  fault
);

    localparam int SCAN_W = $clog2(SCAN_DIV);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam int DIGIT_W = $clog2(NUM_DIGITS);

    light_e       ewCode_q, snCode_q;
    logic [7:0]   count_q, lastConv_q;
    logic         valid_q, fault_q, faultDet, yellowGate;
    logic [2:0]   ewLed_q, ewLed_d, snLed_q, snLed_d;
    logic [SCAN_W-1:0]     scanCnt_q;
    logic [DIGIT_W-1:0]    digit_q;
    logic [7:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q;
    logic         convStart, convBusy, convDone;
    logic [3:0]   hund, tens, units;

    // valid_q keeps decode quiet for the cycle the input registers still hold reset values.
    always_ff @(posedge clk) begin
        if (rst) begin
            ewCode_q <= GREEN;
            snCode_q <= GREEN;
            count_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            ewCode_q <= light_e'(east_west);
            snCode_q <= light_e'(south_north);
            count_q  <= countdown;
            valid_q  <= 1'b1;
        end
    end

    assign faultDet = valid_q && (ewCode_q == ILLEGAL || snCode_q == ILLEGAL ||
                                  (ewCode_q != RED && snCode_q != RED));

`ifdef TRAFFIC_DISP_BLINK_EN
    localparam int BLINK_W = $clog2(BLINK_DIV);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    logic [BLINK_W-1:0] blinkCnt_q;
    logic               blinkPhase_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            blinkCnt_q   <= '0;
            blinkPhase_q <= 1'b1;
        end else if (blinkCnt_q == BLINK_LAST) begin
            blinkCnt_q   <= '0;
            blinkPhase_q <= ~blinkPhase_q;
        end else begin
            blinkCnt_q   <= blinkCnt_q + BLINK_W'(1);
        end
    end

    assign yellowGate = blinkPhase_q;
`else
    assign yellowGate = 1'b1;

    // BLINK_DIV has no effect in the steady-yellow build.
    if (BLINK_DIV < 2) begin : g_blink_div_unused
    end
`endif

    always_comb begin
        ewLed_d = lampOf(ewCode_q);
        snLed_d = lampOf(snCode_q);
        if (fault_q || faultDet) begin
            ewLed_d = 3'b010;
            snLed_d = 3'b010;
        end
        if (!valid_q) begin
            ewLed_d = 3'b000;
            snLed_d = 3'b000;
        end
        ewLed_d = ewLed_d & {1'b1, yellowGate, 1'b1};
        snLed_d = snLed_d & {1'b1, yellowGate, 1'b1};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ewLed_q <= 3'b000;
            snLed_q <= 3'b000;
            fault_q <= 1'b0;
        end else begin
            ewLed_q <= ewLed_d;
            snLed_q <= snLed_d;
            fault_q <= fault_q | faultDet;
        end
    end

    // The idle cycle after done keeps the converter from re-arming on the edge it reports.
    assign convStart = !convBusy && !convDone && (count_q != lastConv_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            lastConv_q <= '0;
        end else if (convStart) begin
            lastConv_q <= count_q;
        end
    end

    bin2bcd_seq u_bcd (
        .clk   (clk),
        .rst   (rst),
        .start (convStart),
        .bin   (count_q),
        .busy  (convBusy),
        .done  (convDone),
        .hund  (hund),
        .tens  (tens),
        .units (units)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            scanCnt_q <= '0;
            digit_q   <= '0;
        end else if (scanCnt_q == SCAN_LAST) begin
            scanCnt_q <= '0;
            digit_q   <= digit_q + DIGIT_W'(1);
        end else begin
            scanCnt_q <= scanCnt_q + SCAN_W'(1);
        end
    end

    always_comb begin
        seg_d = SEG_BLANK;
        case (digit_q)
            2'd0: if (!fault_q) seg_d = segOf(units);
            2'd1: if (!fault_q && (hund != 4'd0 || tens != 4'd0)) seg_d = segOf(tens);
            2'd2: if (!fault_q && hund != 4'd0) seg_d = segOf(hund);
            2'd3: if (fault_q) seg_d = SEG_F;
            default: seg_d = SEG_BLANK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q <= SEG_BLANK;
            an_q  <= 4'b1110;
        end else begin
            seg_q <= seg_d;
            an_q  <= ~(NUM_DIGITS'(1) << digit_q);
        end
    end

    assign ew_led = ewLed_q;
    assign sn_led = snLed_q;
    assign seg    = seg_q;
    assign an     = an_q;
    assign fault  = fault_q;

endmodule

// File: tb/tb_traffic_display_driver.sv
// Directed self-checking bench for traffic_display_driver with SCAN_DIV=4 and
// BLINK_DIV=8; expectations follow TRAFFIC_DISP_BLINK_EN when it is defined.
module tb_traffic_display_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] east_west;
    logic [1:0] south_north;
    logic [7:0] countdown;
    logic [2:0] ew_led;
    logic [2:0] sn_led;
    logic [7:0] seg;
    logic [3:0] an;
    logic       fault;

    int checkCount = 0;
    int failCount  = 0;
    logic [7:0] capSeg [4];
    int anBad;

    traffic_display_driver #(
        .SCAN_DIV  (4),
        .BLINK_DIV (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .east_west   (east_west),
        .south_north (south_north),
        .countdown   (countdown),
        .ew_led      (ew_led),
        .sn_led      (sn_led),
        .seg         (seg),
        .an          (an),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout, expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] ew, input logic [1:0] sn,
                                 input logic [7:0] cd);
        @(posedge clk);
        #1;
        east_west   = ew;
        south_north = sn;
        countdown   = cd;
    endtask

    task automatic settle(input int edges);
        repeat (edges) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic captureDigits();
        for (int i = 0; i < 4; i++) capSeg[i] = 8'h00;
        anBad = 0;
        repeat (20) begin
            @(negedge clk);
            case (an)
                4'b1110: capSeg[0] = seg;
                4'b1101: capSeg[1] = seg;
                4'b1011: capSeg[2] = seg;
                4'b0111: capSeg[3] = seg;
                default: anBad++;
            endcase
        end
    endtask

    task automatic checkDigits(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                               input logic [7:0] e2, input logic [7:0] e3);
        captureDigits();
        checkOutput({tag, "_an_onehot"}, 32'(anBad), 32'd0);
        checkOutput({tag, "_d0"}, 32'(capSeg[0]), 32'(e0));
        checkOutput({tag, "_d1"}, 32'(capSeg[1]), 32'(e1));
        checkOutput({tag, "_d2"}, 32'(capSeg[2]), 32'(e2));
        checkOutput({tag, "_d3"}, 32'(capSeg[3]), 32'(e3));
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_ew_led"}, 32'(ew_led), 32'h0);
        checkOutput({tag, "_sn_led"}, 32'(sn_led), 32'h0);
        checkOutput({tag, "_seg"}, 32'(seg), 32'hFF);
        checkOutput({tag, "_an"}, 32'(an), 32'hE);
        checkOutput({tag, "_fault"}, 32'(fault), 32'h0);
        checkOutput({tag, "_bcd"}, 32'({dut.u_bcd.hund, dut.u_bcd.tens, dut.u_bcd.units}), 32'h0);
    endtask

    initial begin
        logic [3:0] prevAn;
        logic       prevY;
        logic [11:0] bcd;
        int n, trans, lastT, badSpace, otherBad, stage, first100, seen99, seqBad;

        rst = 1'b1;
        east_west = 2'b10;
        south_north = 2'b00;
        countdown = 8'd45;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkResetOutputs("reset");

        // Release reset; lamps follow two edges after the registered inputs.
        @(posedge clk);
        #1 rst = 1'b0;
        settle(1);
        checkOutput("lamp_latency_ew", 32'(ew_led), 32'h0);
        settle(1);
        checkOutput("lamp_ew_red", 32'(ew_led), 32'h4);
        checkOutput("lamp_sn_green", 32'(sn_led), 32'h1);
        checkOutput("no_fault_legal", 32'(fault), 32'h0);

        settle(15);
        checkDigits("cd45", 8'h92, 8'h99, 8'hFF, 8'hFF);

        prevAn = an;
        n = 0;
        while (an == prevAn && n < 10) begin @(negedge clk); n++; end
        prevAn = an;
        n = 0;
        while (an == prevAn && n < 10) begin @(negedge clk); n++; end
        checkOutput("scan_period", 32'(n), 32'd4);
        checkOutput("scan_order", 32'(an), 32'({prevAn[2:0], prevAn[3]}));

        // Yellow south-north lamp over 40 cycles.
        applyStimulus(2'b10, 2'b01, 8'd45);
        settle(3);
        prevY = sn_led[1];
        trans = 0; lastT = -1; badSpace = 0; otherBad = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (sn_led[1] != prevY) begin
                if (lastT >= 0 && (i - lastT) != 8) badSpace++;
                lastT = i;
                trans++;
            end
            prevY = sn_led[1];
            if ((sn_led & 3'b101) != 3'b000 || ew_led != 3'b100) otherBad++;
        end
        checkOutput("blink_other_lamps", 32'(otherBad), 32'd0);
`ifdef TRAFFIC_DISP_BLINK_EN
        checkOutput("blink_toggles", 32'(trans >= 4), 32'd1);
        checkOutput("blink_spacing", 32'(badSpace), 32'd0);
`else
        checkOutput("yellow_steady", 32'(trans), 32'd0);
        checkOutput("yellow_on", 32'(sn_led), 32'h2);
`endif
        checkOutput("no_fault_yellow", 32'(fault), 32'h0);

        // 100 then 99 while the first conversion is still busy.
        applyStimulus(2'b10, 2'b00, 8'd100);
        stage = 0; first100 = -1; seen99 = 0; seqBad = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (k == 3) countdown = 8'd99;
            @(negedge clk);
            bcd = {dut.u_bcd.hund, dut.u_bcd.tens, dut.u_bcd.units};
            if (bcd == 12'h045) begin
                if (stage != 0) seqBad++;
            end else if (bcd == 12'h100) begin
                if (stage == 2) seqBad++;
                if (first100 < 0) first100 = k;
                stage = 1;
            end else if (bcd == 12'h099) begin
                if (stage == 0) seqBad++;
                seen99 = 1;
                stage = 2;
            end else begin
                seqBad++;
            end
        end
        checkOutput("bcd100_latency", 32'(first100), 32'd10);
        checkOutput("bcd99_followup", 32'(seen99), 32'd1);
        checkOutput("bcd_sequence", 32'(seqBad), 32'd0);
        checkDigits("cd99", 8'h90, 8'h90, 8'hFF, 8'hFF);

        applyStimulus(2'b10, 2'b00, 8'd255);
        settle(15);
        checkDigits("cd255", 8'h92, 8'h92, 8'hA4, 8'hFF);
        applyStimulus(2'b10, 2'b00, 8'd0);
        settle(15);
        checkDigits("cd0", 8'hC0, 8'hFF, 8'hFF, 8'hFF);

        // One cycle of green/green is a conflict and must latch.
        applyStimulus(2'b00, 2'b00, 8'd0);
        applyStimulus(2'b10, 2'b00, 8'd0);
        settle(1);
        checkOutput("fault_conflict", 32'(fault), 32'h1);
        checkOutput("fault_lamps_equal", 32'(ew_led == sn_led), 32'd1);
        checkOutput("fault_lamps_yellow_only", 32'(ew_led & 3'b101), 32'd0);
`ifndef TRAFFIC_DISP_BLINK_EN
        checkOutput("fault_lamp_yellow", 32'(ew_led), 32'h2);
`endif
        settle(20);
        checkOutput("fault_sticky", 32'(fault), 32'h1);
        checkDigits("fault", 8'hFF, 8'hFF, 8'hFF, 8'h8E);

        @(posedge clk);
        #1 rst = 1'b1;
        countdown = 8'd45;
        settle(0);
        @(posedge clk);
        @(negedge clk);
        checkResetOutputs("rst_after_conflict");
        @(posedge clk);
        #1 rst = 1'b0;
        settle(3);
        checkOutput("fault_cleared", 32'(fault), 32'h0);

        // Illegal code while a conversion of 45 is in flight, then reset.
        applyStimulus(2'b10, 2'b11, 8'd45);
        settle(1);
        checkOutput("illegal_not_yet", 32'(fault), 32'h0);
        settle(1);
        checkOutput("illegal_fault", 32'(fault), 32'h1);
        @(posedge clk);
        #1 rst = 1'b1;
        south_north = 2'b00;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        checkResetOutputs("rst_mid_conv");
        checkOutput("rst_conv_idle", 32'(dut.u_bcd.busy), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        settle(20);
        checkOutput("recovered_no_fault", 32'(fault), 32'h0);
        checkDigits("recovered", 8'h92, 8'h99, 8'hFF, 8'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
